// File: rtl/sap_ctrl_pkg.sv
// sap_ctrl_pkg: control-word bit indices, one-hot masks and opcodes shared by the sequencer and its microcode ROM.
package sap_ctrl_pkg;

    localparam int HLT = 15;
    localparam int MI  = 14;
    localparam int RI  = 13;
    localparam int RO  = 12;
    localparam int IO  = 11;
    localparam int II  = 10;
    localparam int AI  = 9;
    localparam int AO  = 8;
    localparam int EO  = 7;
    localparam int SU  = 6;
    localparam int BI  = 5;
    localparam int OI  = 4;
    localparam int CE  = 3;
    localparam int CO  = 2;
    localparam int J   = 1;
    localparam int FI  = 0;

    localparam logic [15:0] M_HLT = 16'd1 << HLT;
    localparam logic [15:0] M_MI  = 16'd1 << MI;
    localparam logic [15:0] M_RI  = 16'd1 << RI;
    localparam logic [15:0] M_RO  = 16'd1 << RO;
    localparam logic [15:0] M_IO  = 16'd1 << IO;
    localparam logic [15:0] M_II  = 16'd1 << II;
    localparam logic [15:0] M_AI  = 16'd1 << AI;
    localparam logic [15:0] M_AO  = 16'd1 << AO;
    localparam logic [15:0] M_EO  = 16'd1 << EO;
    localparam logic [15:0] M_SU  = 16'd1 << SU;
    localparam logic [15:0] M_BI  = 16'd1 << BI;
    localparam logic [15:0] M_OI  = 16'd1 << OI;
    localparam logic [15:0] M_CE  = 16'd1 << CE;
    localparam logic [15:0] M_CO  = 16'd1 << CO;
    localparam logic [15:0] M_J   = 16'd1 << J;
    localparam logic [15:0] M_FI  = 16'd1 << FI;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: purely combinational decode of (opcode, step, flags) into the 16-bit control word.
module microcode_rom
    import sap_ctrl_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [2:0]  step,
    input  logic [1:0]  flags,
    output logic [15:0] ctrl
);

    logic [15:0] w_t2;
    logic [15:0] w_t3;
    logic [15:0] w_t4;

    always_comb begin
        w_t2 = '0;
        w_t3 = '0;
        w_t4 = '0;
        case (opcode_e'(opcode))
            OP_LDA: begin w_t2 = M_IO | M_MI; w_t3 = M_RO | M_AI; end
            OP_ADD: begin w_t2 = M_IO | M_MI; w_t3 = M_RO | M_BI; w_t4 = M_EO | M_AI | M_FI; end
            OP_SUB: begin w_t2 = M_IO | M_MI; w_t3 = M_RO | M_BI; w_t4 = M_EO | M_AI | M_SU | M_FI; end
            OP_STA: begin w_t2 = M_IO | M_MI; w_t3 = M_AO | M_RI; end
            OP_LDI: w_t2 = M_IO | M_AI;
            OP_JMP: w_t2 = M_IO | M_J;
            OP_JC:  w_t2 = flags[0] ? (M_IO | M_J) : '0;
            OP_JZ:  w_t2 = flags[1] ? (M_IO | M_J) : '0;
            OP_OUT: w_t2 = M_AO | M_OI;
            OP_HLT: w_t2 = M_HLT;
            default: ;
        endcase
        ctrl = step == 3'd0 ? (M_CO | M_MI) :
               step == 3'd1 ? (M_RO | M_II | M_CE) :
               step == 3'd2 ? w_t2 :
               step == 3'd3 ? w_t3 :
               step == 3'd4 ? w_t4 : '0;
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: microstep counter and halt latch around microcode_rom.
// Optional SEQ_EARLY_END_EN ends an instruction at its first all-zero step at or beyond T2.
module control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int MAX_STEP = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    input  logic [1:0]  flags,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted,
    output logic        alu_bus_enable_n,
    output logic        alu_subtract,
    output logic        flag_fi_n
);

    logic [15:0] w_rom;
    logic        w_end;
    logic [2:0]  r_step;
    logic        r_halted;

    microcode_rom u_rom (
        .opcode(opcode),
        .step  (r_step),
        .flags (flags),
        .ctrl  (w_rom)
    );

`ifdef SEQ_EARLY_END_EN
    assign w_end = (r_step == 3'(MAX_STEP)) || (r_step >= 3'd2 && w_rom == '0);
`else
    assign w_end = r_step == 3'(MAX_STEP);
`endif

    // Once halted the word is pinned so opcode/flag changes cannot disturb the outputs.
    assign ctrl             = r_halted ? M_HLT : w_rom;
    assign step             = r_step;
    assign halted           = r_halted;
    assign alu_bus_enable_n = ~ctrl[EO];
    assign alu_subtract     = ctrl[SU];
    assign flag_fi_n        = ~ctrl[FI];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_step   <= '0;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (w_rom[HLT])
                r_halted <= 1'b1;
            else
                r_step <= w_end ? '0 : r_step + 3'd1;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized checks of control_sequencer against a table-driven reference model.
// Honours SEQ_EARLY_END_EN so the same bench covers both builds.
module tb_control_sequencer;

    localparam int MAX_STEP = 4;
`ifdef SEQ_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [15:0] W_HLT = 16'h8000;
    localparam logic [15:0] W_MI  = 16'h4000;
    localparam logic [15:0] W_RI  = 16'h2000;
    localparam logic [15:0] W_RO  = 16'h1000;
    localparam logic [15:0] W_IO  = 16'h0800;
    localparam logic [15:0] W_II  = 16'h0400;
    localparam logic [15:0] W_AI  = 16'h0200;
    localparam logic [15:0] W_AO  = 16'h0100;
    localparam logic [15:0] W_EO  = 16'h0080;
    localparam logic [15:0] W_SU  = 16'h0040;
    localparam logic [15:0] W_BI  = 16'h0020;
    localparam logic [15:0] W_OI  = 16'h0010;
    localparam logic [15:0] W_CE  = 16'h0008;
    localparam logic [15:0] W_CO  = 16'h0004;
    localparam logic [15:0] W_J   = 16'h0002;
    localparam logic [15:0] W_FI  = 16'h0001;
    localparam logic [15:0] DRV   = W_CO | W_RO | W_IO | W_AO | W_EO;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  opcode;
    logic [1:0]  flags;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;
    logic        alu_bus_enable_n;
    logic        alu_subtract;
    logic        flag_fi_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tab [16][3];
    logic [2:0]  m_step;
    logic        m_halt;
    logic [2:0]  seen [$];
    logic [2:0]  want [$];

    control_sequencer #(.MAX_STEP(MAX_STEP)) dut (
        .clk             (clk),
        .clr             (clr),
        .opcode          (opcode),
        .flags           (flags),
        .ctrl            (ctrl),
        .step            (step),
        .halted          (halted),
        .alu_bus_enable_n(alu_bus_enable_n),
        .alu_subtract    (alu_subtract),
        .flag_fi_n       (flag_fi_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] uword(input logic [3:0] op, input logic [2:0] st, input logic [1:0] fl);
        if (st == 3'd0) return W_CO | W_MI;
        if (st == 3'd1) return W_RO | W_II | W_CE;
        if (st > 3'd4) return 16'h0;
        if (op == 4'h7 && st == 3'd2 && !fl[0]) return 16'h0;
        if (op == 4'h8 && st == 3'd2 && !fl[1]) return 16'h0;
        return tab[op][int'(st) - 2];
    endfunction

    task automatic tick();
        logic [15:0] w;
        @(negedge clk);
        w = m_halt ? W_HLT : uword(opcode, m_step, flags);
        check("ctrl", ctrl, w);
        check("step", {13'b0, step}, {13'b0, m_step});
        check("halted", {15'b0, halted}, {15'b0, m_halt});
        check("alu_bus_enable_n", {15'b0, alu_bus_enable_n}, {15'b0, (w & W_EO) == 16'h0});
        check("alu_subtract", {15'b0, alu_subtract}, {15'b0, (w & W_SU) != 16'h0});
        check("flag_fi_n", {15'b0, flag_fi_n}, {15'b0, (w & W_FI) == 16'h0});
        check("one_driver", {15'b0, $countones(ctrl & DRV) <= 1}, 16'd1);
        @(posedge clk);
        if (clr) begin
            m_step = 3'd0;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if ((w & W_HLT) != 16'h0) m_halt = 1'b1;
            else if (EARLY && m_step >= 3'd2 && w == 16'h0) m_step = 3'd0;
            else m_step = (m_step == 3'(MAX_STEP)) ? 3'd0 : m_step + 3'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        foreach (tab[i, k]) tab[i][k] = 16'h0;
        tab[1] = '{W_IO | W_MI, W_RO | W_AI, 16'h0};
        tab[2] = '{W_IO | W_MI, W_RO | W_BI, W_EO | W_AI | W_FI};
        tab[3] = '{W_IO | W_MI, W_RO | W_BI, W_EO | W_AI | W_SU | W_FI};
        tab[4] = '{W_IO | W_MI, W_AO | W_RI, 16'h0};
        tab[5] = '{W_IO | W_AI, 16'h0, 16'h0};
        tab[6] = '{W_IO | W_J, 16'h0, 16'h0};
        tab[7] = '{W_IO | W_J, 16'h0, 16'h0};
        tab[8] = '{W_IO | W_J, 16'h0, 16'h0};
        tab[14] = '{W_AO | W_OI, 16'h0, 16'h0};
        tab[15] = '{W_HLT, 16'h0, 16'h0};
        clr = 1'b1;
        opcode = 4'h0;
        flags = 2'b00;
        @(posedge clk);
        #1;
        m_step = 3'd0;
        m_halt = 1'b0;
        clr = 1'b0;
        check("rst_ctrl", ctrl, 16'h4004);
        check("rst_step", {13'b0, step}, 16'd0);
        check("rst_halted", {15'b0, halted}, 16'd0);
        check("rst_aben", {15'b0, alu_bus_enable_n}, 16'd1);
        check("rst_asub", {15'b0, alu_subtract}, 16'd0);
        check("rst_fin", {15'b0, flag_fi_n}, 16'd1);

        // SUB runs to T4 and wraps
        do_reset();
        opcode = 4'h3;
        repeat (4) tick();
        check("sub_t4_ctrl", ctrl, 16'h02C1);
        check("sub_t4_asub", {15'b0, alu_subtract}, 16'd1);
        check("sub_t4_aben", {15'b0, alu_bus_enable_n}, 16'd0);
        check("sub_t4_fin", {15'b0, flag_fi_n}, 16'd0);
        tick();
        check("sub_wrap_step", {13'b0, step}, 16'd0);

        // conditional jumps sampled at T2
        do_reset();
        opcode = 4'h7;
        flags = 2'b01;
        repeat (2) tick();
        check("jc_taken", ctrl, 16'h0802);
        flags = 2'b00;
        #1 check("jc_not_taken", ctrl, 16'h0000);
        flags = 2'b10;
        #1 check("jc_zero_only", ctrl, 16'h0000);
        repeat (3) tick();
        do_reset();
        opcode = 4'h8;
        flags = 2'b10;
        repeat (2) tick();
        check("jz_taken", ctrl, 16'h0802);
        flags = 2'b01;
        #1 check("jz_not_taken", ctrl, 16'h0000);
        repeat (3) tick();

        // halt freezes step until clr
        do_reset();
        opcode = 4'hF;
        repeat (2) tick();
        check("hlt_t2_ctrl", ctrl, 16'h8000);
        tick();
        check("hlt_halted", {15'b0, halted}, 16'd1);
        repeat (10) begin
            opcode = 4'($urandom);
            flags = 2'($urandom);
            tick();
        end
        check("hlt_frozen_step", {13'b0, step}, 16'd2);
        check("hlt_frozen_ctrl", ctrl, 16'h8000);
        do_reset();
        check("hlt_clr_step", {13'b0, step}, 16'd0);
        check("hlt_clr_halted", {15'b0, halted}, 16'd0);

        // LDI step sequence
        do_reset();
        opcode = 4'h5;
        want = EARLY ? '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1} : '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        seen = {};
        repeat (6) begin
            seen.push_back(step);
            tick();
        end
        foreach (want[i]) check($sformatf("ldi_seq%0d", i), {13'b0, seen[i]}, {13'b0, want[i]});

        // clr during ADD T3 abandons the instruction
        do_reset();
        opcode = 4'h2;
        repeat (3) tick();
        check("add_t3_fin", {15'b0, flag_fi_n}, 16'd1);
        clr = 1'b1;
        #1 check("add_clr_fin", {15'b0, flag_fi_n}, 16'd1);
        tick();
        clr = 1'b0;
        check("add_clr_step", {13'b0, step}, 16'd0);
        check("add_clr_ctrl", ctrl, 16'h4004);
        check("add_clr_fin2", {15'b0, flag_fi_n}, 16'd1);

        // randomized traffic
        repeat (500) begin
            if (m_step == 3'd0 || $urandom_range(0, 9) == 0) opcode = 4'($urandom);
            flags = 2'($urandom);
            clr = ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            tick();
        end
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
- REQ-001: Parameter SHALL be MAX_STEP, default 4; index of the last microstep (T0..T4).
- REQ-002: clk  input  1  system clock; all state SHALL change on its rising edge only.
- REQ-003: clr  input  1  reset, synchronous, active-high.
- REQ-004: opcode  input  4  upper nibble of the instruction register.
- REQ-005: flags  input  2  registered ALU flags; bit0 carry, bit1 zero.
- REQ-006: ctrl  output  16  active-high control word; bit map per REQ-026.
- REQ-007: step  output  3  current microstep index.
- REQ-008: halted  output  1  high while the HLT state is held.
- REQ-009: alu_bus_enable_n  output  1  active-low ALU bus drive; SHALL equal ~ctrl[EO].
- REQ-010: alu_subtract  output  1  ALU subtract select; SHALL equal ctrl[SU].
- REQ-011: flag_fi_n  output  1  active-low flag-register load; SHALL equal ~ctrl[FI].

Function
- REQ-012: ctrl SHALL be a combinational decode of (opcode, step, flags), valid in the same cycle, with zero added latency.
- REQ-013: T0 SHALL be CO|MI; T1 SHALL be RO|II|CE, for every opcode.
- REQ-014: Steps T2..T4 by opcode:
  - 0 NOP: none
  - 1 LDA: IO|MI, RO|AI
  - 2 ADD: IO|MI, RO|BI, EO|AI|FI
  - 3 SUB: IO|MI, RO|BI, EO|AI|SU|FI
  - 4 STA: IO|MI, AO|RI
  - 5 LDI: IO|AI
  - 6 JMP: IO|J
  - 7 JC: IO|J only if flags[0]=1
  - 8 JZ: IO|J only if flags[1]=1
  - E OUT: AO|OI
  - F HLT: HLT
  - All other opcodes SHALL decode as NOP. Unlisted steps SHALL be zero.
- REQ-015: step SHALL increment by 1 per clock and wrap from MAX_STEP to 0.
- REQ-016: When ctrl[HLT]=1 at a rising edge, the block SHALL set halted and freeze step.
- REQ-017: While halted, ctrl SHALL hold the HLT word and all other outputs SHALL stay constant until clr.
- REQ-018: JC/JZ SHALL sample flags combinationally during T2; flag changes at other steps SHALL have no effect.
- REQ-019: Never more than one bus-driver bit (CO, RO, IO, AO, EO) SHALL be set in any ctrl word.

Reset
- REQ-020: clr=1 at a rising edge SHALL force step=0 and halted=0, overriding halt, increment and early-end.
- REQ-021: After reset, ctrl SHALL be CO|MI, alu_bus_enable_n=1, alu_subtract=0 and flag_fi_n=1.
- REQ-022: clr asserted mid-instruction SHALL abandon that instruction; no partial step SHALL be replayed.

Configuration
- REQ-023: The macro SHALL be SEQ_EARLY_END_EN.
- REQ-024: With SEQ_EARLY_END_EN defined, a step>=2 whose decoded ctrl is all-zero SHALL load step=0 at the next edge.
  - Example: LDI takes 4 cycles; NOP takes 3.
- REQ-025: With SEQ_EARLY_END_EN undefined, every instruction SHALL take MAX_STEP+1 cycles.

Structure
- REQ-026: Package sap_ctrl_pkg SHALL hold the bit-index constants and the opcode constants.
  - Bit indices: HLT=15, MI=14, RI=13, RO=12, IO=11, II=10, AI=9, AO=8, EO=7, SU=6, BI=5, OI=4, CE=3, CO=2, J=1, FI=0.
  - Opcodes: NOP through HLT.
- REQ-027: The decode of REQ-013/014 SHALL live in sub-module microcode_rom (purely combinational).
- REQ-028: The step counter and halt latch SHALL live in control_sequencer.

Verification
- REQ-029: clr=1 for 1 cycle -> step=0, ctrl=16'h4004, halted=0.
- REQ-030: opcode=3 (SUB), 5 clocks -> at T4: ctrl has EO|AI|SU|FI, alu_subtract=1, alu_bus_enable_n=0, flag_fi_n=0; step returns to 0.
- REQ-031: opcode=7 (JC) at T2:
  - flags=2'b01 -> ctrl=IO|J
  - flags=2'b00 -> ctrl=0
  - same check for JZ with flags=2'b10.
- REQ-032: opcode=F reaching T2 -> halted=1 from the next edge; step stays 2 for 10 clocks; clr then gives step=0, halted=0.
- REQ-033: SEQ_EARLY_END_EN defined, opcode=5 -> step sequence 0,1,2,3,0.
  - Undefined -> 0,1,2,3,4,0.
- REQ-034: clr asserted at T3 of ADD -> next cycle step=0, ctrl=CO|MI, flag_fi_n stays 1 throughout.
